// File: rtl/accumulator_bank_array_pkg.sv
// Shared definitions for the banked output-tile accumulator.
// Provides the controller state encoding, the row/column address types used
// by the upstream neighbour stage, the (row, column) -> bank-local address
// mapping and the per-bank depth derivation.
package accumulator_bank_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FLUSH,
    ST_DRAIN
  } state_t;

  localparam int unsigned DEFAULT_TILE_SIZE = 128;

  typedef logic [$clog2(DEFAULT_TILE_SIZE)-1:0] row_t;
  typedef logic [$clog2(DEFAULT_TILE_SIZE)-1:0] col_t;

  // Entries held by each bank for a square tile spread across all banks.
  function automatic int unsigned depth_of(input int unsigned tile,
                                           input int unsigned banks);
    return (tile * tile) / banks;
  endfunction

  // Columns are rotated across banks within a row, so each row occupies
  // tile/banks consecutive entries of every bank.
  function automatic int unsigned addr_from_rc(input int unsigned row,
                                               input int unsigned col,
                                               input int unsigned tile,
                                               input int unsigned banks);
    return row * (tile / banks) + col / banks;
  endfunction

endpackage

// File: rtl/accumulator_bank_array_bank.sv
// Single accumulator bank: DEPTH x DATA_WIDTH array with a 2-stage
// read-modify-write pipeline, one-deep forwarding, and a shared write/read
// port mux for clear and drain traffic.
// Build option: `define SATURATE_EN for saturating adds (default: wrap).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   i_wr_en/addr/data       accumulate request (S1)
//   i_clr_en/i_clr_addr     write zero at i_clr_addr
//   i_rd_en/i_rd_addr       drain read; o_rd_data holds until next read
//   o_rd_data               registered read data
//   o_busy                  RMW pipeline holds a pending write-back
module accumulator_bank_array_bank
  import accumulator_bank_array_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH = 16,
  parameter int unsigned  DEPTH      = 512,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_clr_en,
  input  logic [AW-1:0]         i_clr_addr,
  input  logic                  i_rd_en,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_busy
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  r_s1_valid;
  logic [AW-1:0]         r_s1_addr;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic [DATA_WIDTH-1:0] r_rd;

  logic [DATA_WIDTH-1:0] w_sum_wrap;
  logic [DATA_WIDTH-1:0] w_sum;
  logic                  w_fwd;
  logic                  w_mem_we;
  logic [AW-1:0]         w_mem_waddr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  // S2: r_rd is the operand read (or forwarded) when the request entered S1.
  always_comb begin
    w_sum_wrap = r_rd + r_s1_data;
    w_sum      = w_sum_wrap;
`ifdef SATURATE_EN
    if ((r_rd[DATA_WIDTH-1] == r_s1_data[DATA_WIDTH-1]) &&
        (w_sum_wrap[DATA_WIDTH-1] != r_rd[DATA_WIDTH-1]))
      w_sum = r_rd[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif
  end

  // The array write for S2 lands on the same edge as the S1 read of a
  // follow-up hit, so that read must take the sum instead of stale memory.
  assign w_fwd = r_s1_valid && (r_s1_addr == i_wr_addr);

  // Clear only runs with an empty pipeline, so the two writers never collide.
  assign w_mem_we    = i_clr_en || r_s1_valid;
  assign w_mem_waddr = i_clr_en ? i_clr_addr : r_s1_addr;
  assign w_mem_wdata = i_clr_en ? '0 : w_sum;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_data  <= '0;
      r_rd       <= '0;
    end else begin
      r_s1_valid <= i_wr_en;
      if (i_wr_en) begin
        r_s1_addr <= i_wr_addr;
        r_s1_data <= i_wr_data;
        r_rd      <= w_fwd ? w_sum : r_mem[i_wr_addr];
      end else if (i_rd_en) begin
        r_rd <= r_mem[i_rd_addr];
      end
    end
  end

  assign o_rd_data = r_rd;
  assign o_busy    = r_s1_valid;

endmodule

// File: rtl/accumulator_bank_array.sv
// Banked output-tile accumulator: BANK_COUNT accumulator banks under a
// clear/flush/drain controller. Writes are accepted only in IDLE; writes in
// any other state are discarded and flagged on the sticky dropped_write.
// Build option: `define SATURATE_EN for saturating adds (default: wrap).
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   buffer_*_write[BANK_COUNT]     per-bank row/column/data/enable
//   clear_start, drain_start       operation start pulses (clear wins)
//   drain_ready/valid/addr/data    bank-parallel drain stream
//   busy                           not IDLE or RMW pipeline non-empty
//   dropped_write                  sticky: write seen outside IDLE
module accumulator_bank_array
  import accumulator_bank_array_pkg::*;
#(
  parameter int unsigned  BANK_COUNT = 32,
  parameter int unsigned  TILE_SIZE  = 128,
  parameter int unsigned  DATA_WIDTH = 16,
  localparam int unsigned DEPTH      = depth_of(TILE_SIZE, BANK_COUNT),
  localparam int unsigned AW         = $clog2(DEPTH),
  localparam int unsigned RW         = $clog2(TILE_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [RW-1:0]         buffer_row_write    [BANK_COUNT],
  input  logic [RW-1:0]         buffer_column_write [BANK_COUNT],
  input  logic [DATA_WIDTH-1:0] buffer_data_write   [BANK_COUNT],
  input  logic                  buffer_write_enable [BANK_COUNT],
  input  logic                  clear_start,
  input  logic                  drain_start,
  input  logic                  drain_ready,
  output logic                  drain_valid,
  output logic [AW-1:0]         drain_addr,
  output logic [DATA_WIDTH-1:0] drain_data [BANK_COUNT],
  output logic                  busy,
  output logic                  dropped_write
);

  state_t        r_state;
  logic          r_pend_clear;
  logic [AW-1:0] r_clr_addr;
  logic [AW-1:0] r_rd_ptr;
  logic          r_rd_done;
  logic          r_valid;
  logic [AW-1:0] r_drain_addr;
  logic          r_dropped;

  logic [BANK_COUNT-1:0] w_we_vec;
  logic [BANK_COUNT-1:0] w_pipe_vec;
  logic                  w_xfer;
  logic                  w_issue;
  logic                  w_clr_en;

  assign w_xfer   = r_valid && drain_ready;
  // A new read is issued when the output slot is empty or being vacated.
  assign w_issue  = (r_state == ST_DRAIN) && !r_rd_done && (!r_valid || w_xfer);
  assign w_clr_en = (r_state == ST_CLEAR);

  for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
    logic [AW-1:0] w_wr_addr;
    logic          w_wr_en;

    assign w_we_vec[b] = buffer_write_enable[b];
    assign w_wr_en     = buffer_write_enable[b] && (r_state == ST_IDLE);
    assign w_wr_addr   = AW'(addr_from_rc(32'(buffer_row_write[b]),
                                          32'(buffer_column_write[b]),
                                          TILE_SIZE, BANK_COUNT));

    accumulator_bank_array_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_bank (
      .clk        (clk),
      .rst_n      (reset_n),
      .i_wr_en    (w_wr_en),
      .i_wr_addr  (w_wr_addr),
      .i_wr_data  (buffer_data_write[b]),
      .i_clr_en   (w_clr_en),
      .i_clr_addr (r_clr_addr),
      .i_rd_en    (w_issue),
      .i_rd_addr  (r_rd_ptr),
      .o_rd_data  (drain_data[b]),
      .o_busy     (w_pipe_vec[b])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_pend_clear <= 1'b0;
      r_clr_addr   <= '0;
      r_rd_ptr     <= '0;
      r_rd_done    <= 1'b0;
      r_valid      <= 1'b0;
      r_drain_addr <= '0;
      r_dropped    <= 1'b0;
    end else begin
      if ((r_state != ST_IDLE) && (|w_we_vec)) r_dropped <= 1'b1;

      unique case (r_state)
        ST_IDLE: begin
          if (clear_start) begin
            r_state      <= ST_FLUSH;
            r_pend_clear <= 1'b1;
          end else if (drain_start) begin
            r_state      <= ST_FLUSH;
            r_pend_clear <= 1'b0;
          end
        end
        // Both clear and drain wait here for writes accepted on the start
        // cycle to retire before touching the array.
        ST_FLUSH: begin
          if (!(|w_pipe_vec)) begin
            if (r_pend_clear) begin
              r_state    <= ST_CLEAR;
              r_clr_addr <= '0;
            end else begin
              r_state   <= ST_DRAIN;
              r_rd_ptr  <= '0;
              r_rd_done <= 1'b0;
            end
          end
        end
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + AW'(1);
          if (r_clr_addr == AW'(DEPTH - 1)) r_state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (w_issue) begin
            r_valid      <= 1'b1;
            r_drain_addr <= r_rd_ptr;
            r_rd_ptr     <= r_rd_ptr + AW'(1);
            if (r_rd_ptr == AW'(DEPTH - 1)) r_rd_done <= 1'b1;
          end else if (w_xfer) begin
            r_valid <= 1'b0;
            if (r_drain_addr == AW'(DEPTH - 1)) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign drain_valid   = r_valid;
  assign drain_addr    = r_drain_addr;
  assign dropped_write = r_dropped;
  assign busy          = (r_state != ST_IDLE) || (|w_pipe_vec);

endmodule

// File: tb/tb_accumulator_bank_array.sv
module tb_accumulator_bank_array;

  localparam int NB    = 32;
  localparam int DEPTH = 512;

`ifdef SATURATE_EN
  localparam logic [15:0] SAT_EXP = 16'h7FFF;
`else
  localparam logic [15:0] SAT_EXP = 16'h8010;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  row_w  [NB];
  logic [6:0]  col_w  [NB];
  logic [15:0] data_w [NB];
  logic        we     [NB];
  logic        clear_start, drain_start, drain_ready;
  logic        drain_valid;
  logic [8:0]  daddr;
  logic [15:0] dd [NB];
  logic        busy, dropped_write;

  logic [15:0] exp_mem [NB][DEPTH];
  logic [15:0] got     [NB][DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          we;
    int          bank;
    int          row;
    int          col;
    logic [15:0] data;
  } wr_vec_t;

  typedef struct {
    int          bank;
    int          addr;
    logic [15:0] value;
  } exp_vec_t;

  always #5 clk = ~clk;

  accumulator_bank_array dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .buffer_row_write    (row_w),
    .buffer_column_write (col_w),
    .buffer_data_write   (data_w),
    .buffer_write_enable (we),
    .clear_start         (clear_start),
    .drain_start         (drain_start),
    .drain_ready         (drain_ready),
    .drain_valid         (drain_valid),
    .drain_addr          (daddr),
    .drain_data          (dd),
    .busy                (busy),
    .dropped_write       (dropped_write)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] madd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    s = a + b;
`ifdef SATURATE_EN
    if (a[15] == b[15] && s[15] != a[15]) s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    return s;
  endfunction

  function automatic int maddr(input int r, input int c);
    return r * 4 + c / 32;
  endfunction

  task automatic model_zero();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) exp_mem[b][a] = 16'h0000;
  endtask

  task automatic clear_we();
    for (int b = 0; b < NB; b++) we[b] = 1'b0;
  endtask

  task automatic put_write(input int bank, input int r, input int c, input logic [15:0] d);
    we[bank]     = 1'b1;
    row_w[bank]  = 7'(r);
    col_w[bank]  = 7'(c);
    data_w[bank] = d;
  endtask

  task automatic do_clear(input bit with_drain);
    int n;
    bit saw;
    n   = 0;
    saw = 1'b0;
    clear_start = 1'b1;
    drain_start = with_drain;
    tick();
    clear_start = 1'b0;
    drain_start = 1'b0;
    while (busy && n < 2000) begin
      n++;
      drain_start = with_drain && (n == 5);
      if (drain_valid) saw = 1'b1;
      tick();
    end
    drain_start = 1'b0;
    check("clear_busy_cycles", 64'(n), 64'(513));
    if (with_drain) check("clear_wins_over_drain", 64'(saw), 64'(0));
    model_zero();
  endtask

  // Drain the whole array; stall uses ready pattern 1,0,0,1.
  // poke_cyc >= 0 drives one write on bank 3 at that cycle (must be dropped).
  task automatic run_drain(input bit stall, input int poke_cyc, input int exp_lat);
    bit          pat [4];
    int          beat, cyc, first, fb;
    bit          held;
    logic [8:0]  h_addr;
    logic [15:0] h_d0, h_d31;
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
    beat  = 0;
    cyc   = 0;
    first = -1;
    held  = 1'b0;
    h_addr = '0;
    h_d0  = '0;
    h_d31 = '0;
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    clear_we();
    while (beat < DEPTH && cyc < 3000) begin
      drain_ready = stall ? pat[cyc % 4] : 1'b1;
      clear_we();
      if (cyc == poke_cyc) put_write(3, 2, 35, 16'h0100);
      if (drain_valid) begin
        if (first < 0) first = cyc;
        if (held)
          check($sformatf("hold_beat%0d", beat), {23'd0, daddr, dd[0], dd[31]},
                {23'd0, h_addr, h_d0, h_d31});
        if (drain_ready) begin
          fb = 0;
          for (int b = 0; b < NB; b++)
            if (dd[b] !== exp_mem[b][beat]) begin
              fb = b;
              break;
            end
          check($sformatf("beat%0d_addr", beat), 64'(daddr), 64'(beat));
          check($sformatf("beat%0d_bank%0d", beat, fb), 64'(dd[fb]), 64'(exp_mem[fb][beat]));
          for (int b = 0; b < NB; b++) got[b][daddr] = dd[b];
          beat++;
          held = 1'b0;
        end else begin
          held   = 1'b1;
          h_addr = daddr;
          h_d0   = dd[0];
          h_d31  = dd[31];
        end
      end
      tick();
      cyc++;
    end
    clear_we();
    drain_ready = 1'b0;
    check("drain_beat_count", 64'(beat), 64'(DEPTH));
    check("first_valid_latency", 64'(first), 64'(exp_lat));
    check("drain_end_valid", 64'(drain_valid), 64'(0));
    check("drain_end_busy", 64'(busy), 64'(0));
  endtask

  wr_vec_t  wv [16];
  exp_vec_t ev [7];

  initial begin
    reset_n     = 1'b0;
    clear_start = 1'b0;
    drain_start = 1'b0;
    drain_ready = 1'b0;
    for (int b = 0; b < NB; b++) begin
      row_w[b]  = '0;
      col_w[b]  = '0;
      data_w[b] = '0;
      we[b]     = 1'b0;
    end
    tick();
    tick();
    check("reset_valid", 64'(drain_valid), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_dropped", 64'(dropped_write), 64'(0));
    check("reset_addr", 64'(daddr), 64'(0));
    check("reset_data0", 64'(dd[0]), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Clear, then a full zero drain.
    do_clear(1'b0);
    run_drain(1'b0, -1, 2);

    // Directed write table: forwarding, wrap, address mapping, add overflow.
    wv = '{
      '{1'b1,  3,   2,  35, 16'h0005},
      '{1'b1,  3,   2,  35, 16'h0005},
      '{1'b0,  0,   0,   0, 16'h0000},
      '{1'b0,  0,   0,   0, 16'h0000},
      '{1'b0,  0,   0,   0, 16'h0000},
      '{1'b1,  3,   2,  35, 16'hFFFE},
      '{1'b1,  0,   0,   0, 16'h0007},
      '{1'b1,  0,   0,   0, 16'h0003},
      '{1'b1,  5, 127, 127, 16'd100},
      '{1'b1,  5, 127,  96, 16'd1},
      '{1'b1, 31,   1,  64, 16'h8000},
      '{1'b1, 31,   1,  64, 16'h0001},
      '{1'b1, 31,   1,  65, 16'h0002},
      '{1'b1,  7,  10,   0, 16'h7FF0},
      '{1'b1,  7,  10,   0, 16'h0020},
      '{1'b0,  0,   0,   0, 16'h0000}
    };
    ev = '{
      '{ 3,   9, 16'h0008},
      '{ 0,   0, 16'h000A},
      '{ 5, 511, 16'd101},
      '{31,   6, 16'h8003},
      '{ 7,  40, SAT_EXP},
      '{ 3,   8, 16'h0000},
      '{ 4,   9, 16'h0000}
    };
    for (int i = 0; i < 16; i++) begin
      clear_we();
      if (wv[i].we) begin
        put_write(wv[i].bank, wv[i].row, wv[i].col, wv[i].data);
        exp_mem[wv[i].bank][maddr(wv[i].row, wv[i].col)] =
          madd(exp_mem[wv[i].bank][maddr(wv[i].row, wv[i].col)], wv[i].data);
      end
      tick();
    end
    clear_we();
    run_drain(1'b0, -1, 2);
    for (int i = 0; i < 7; i++)
      check($sformatf("table_b%0d_a%0d", ev[i].bank, ev[i].addr),
            64'(got[ev[i].bank][ev[i].addr]), 64'(ev[i].value));

    // Every bank writes every cycle for 10 cycles, then a stalled drain.
    for (int c = 0; c < 10; c++) begin
      for (int b = 0; b < NB; b++) begin
        put_write(b, 20, b * 4, 16'h0001);
        exp_mem[b][maddr(20, b * 4)] = madd(exp_mem[b][maddr(20, b * 4)], 16'h0001);
      end
      tick();
    end
    clear_we();
    check("allbank_dropped", 64'(dropped_write), 64'(0));
    run_drain(1'b1, -1, 2);
    check("allbank_b0_a80", 64'(got[0][80]), 64'(10));
    check("allbank_b8_a81", 64'(got[8][81]), 64'(10));
    check("allbank_b31_a83", 64'(got[31][83]), 64'(10));

    // Write during DRAIN is dropped and flagged; drained data unchanged.
    run_drain(1'b0, 40, 2);
    check("drop_sticky", 64'(dropped_write), 64'(1));
    check("drop_b3_a9_unchanged", 64'(got[3][9]), 64'(16'h0008));

    // Reset mid-drain.
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    drain_ready = 1'b1;
    repeat (10) tick();
    check("middrain_valid", 64'(drain_valid), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_drain_valid", 64'(drain_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_dropped", 64'(dropped_write), 64'(0));
    drain_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Clear beats drain on the same cycle; then a write on the drain_start cycle.
    do_clear(1'b1);
    put_write(2, 0, 0, 16'h0009);
    exp_mem[2][0] = 16'h0009;
    run_drain(1'b0, -1, 3);
    check("start_write_b2_a0", 64'(got[2][0]), 64'(16'h0009));
    check("start_write_b2_a1", 64'(got[2][1]), 64'(16'h0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual timeout required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/accumulator_bank_array.md
Name: accumulator_bank_array

Overview:
- Banked output-tile accumulator directly downstream of the neighbour input stage.
- Consumes the per-bank write ports (row, column, data, enable per bank) and adds each value into a per-bank SRAM-style array via a 2-stage read-modify-write pipeline.
- Provides a clear sequence and a bank-parallel drain stream (valid/ready) for readout of the finished tile.
- Never stalls its producer; the upstream stage already guarantees at most one write per bank per cycle.

Parameters:
- BANK_COUNT, 32, number of banks, power of two.
- TILE_SIZE, 128, tile edge length, power of two, a multiple of BANK_COUNT.
- DATA_WIDTH, 16, accumulator and input data width (two's complement).
- DEPTH (localparam), TILE_SIZE*TILE_SIZE/BANK_COUNT, entries per bank.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- buffer_row_write[BANK_COUNT]  input  $clog2(TILE_SIZE)  row of the incoming write.
- buffer_column_write[BANK_COUNT]  input  $clog2(TILE_SIZE)  column of the incoming write.
- buffer_data_write[BANK_COUNT]  input  DATA_WIDTH  value to add.
- buffer_write_enable[BANK_COUNT]  input  1  per-bank write strobe.
- clear_start  input  1  pulse: zero all entries.
- drain_start  input  1  pulse: stream all entries out.
- drain_ready  input  1  consumer accepts the drain beat.
- drain_valid  output  1  drain beat valid.
- drain_addr  output  $clog2(DEPTH)  bank-local address of the beat.
- drain_data[BANK_COUNT]  output  DATA_WIDTH  one entry per bank at drain_addr.
- busy  output  1  state is not IDLE, or the RMW pipeline is non-empty.
- dropped_write  output  1  sticky error: a write arrived while in CLEAR or DRAIN.

Behaviour:
- Address mapping: bank-local addr = row*(TILE_SIZE/BANK_COUNT) + column/BANK_COUNT. This is unique per bank because the upstream bank function rotates columns within a row.
- Reset: all outputs 0, state IDLE, pipeline valids 0. Array contents are undefined until a CLEAR completes.
- Writes are accepted in IDLE only.
- RMW pipeline, per bank:
  - Cycle t (S1): register addr/data/valid and issue the synchronous read.
  - Cycle t+1 (S2): sum = read + data; write sum at the same addr.
  - Forwarding: if S2 is valid with the same addr as the new S1 in the same bank, S1 uses S2's sum instead of the array read. Back-to-back hits to one address must accumulate exactly.
  - A write is visible to drain reads from cycle t+2.
- Arithmetic: DATA_WIDTH two's-complement add, wrap-around (see Optional Feature).
- FSM states: IDLE, CLEAR, FLUSH, DRAIN.
  - IDLE + clear_start -> CLEAR. Writes all banks at addr 0..DEPTH-1, one addr per cycle, value 0; DEPTH cycles, then IDLE.
  - IDLE + drain_start -> FLUSH. Wait until both pipeline stages are empty (at most 2 cycles), then DRAIN.
  - DRAIN: addresses 0..DEPTH-1 in order. A beat transfers when drain_valid && drain_ready. drain_addr/drain_data are held stable while valid && !ready. With ready held high, throughput is 1 beat/cycle after the first beat; the first valid arrives at most 2 cycles after entering DRAIN. After the beat at addr DEPTH-1 transfers -> IDLE, drain_valid 0.
  - clear_start and drain_start in the same cycle: clear wins, drain ignored. Either start outside IDLE: ignored.
- Write with enable in the same cycle as a start pulse in IDLE: accepted, and completes before the new state acts on the array. CLEAR starts only after the pipeline empties, so CLEAR also passes through FLUSH, tracked by a pending-op flag.
- Write during CLEAR/FLUSH-for-clear/DRAIN: discarded, dropped_write set to 1. dropped_write clears only on reset.
- Reset asserted mid-operation: immediate return to IDLE, in-flight writes lost, drain_valid 0.

Optional Feature:
- SATURATE_EN defined: the S2 add saturates to the DATA_WIDTH signed max/min. Overflow detection uses the operand sign bits; forwarded values are already saturated.
- SATURATE_EN undefined: plain wrap-around add.

Decomposition:
- Shared package: state enum (IDLE, CLEAR, FLUSH, DRAIN), an addr_from_rc function, and a DEPTH-derivation helper. The upstream neighbour stage shares the package's row/column width typedefs.
- Natural sub-module: accumulator_bank. It holds the single-bank array, the 2-stage RMW pipeline with forwarding, the clear/drain read-write mux and the saturate option. It is instantiated BANK_COUNT times under the FSM/drain controller.

Test Plan:
- Reset, then clear_start: busy stays high for DEPTH(+flush) cycles, then drain with ready=1. All 512 beats carry 0 in every bank; addr runs 0..511.
- After clear, write bank 3 row 2 col 35 data 5 on cycles t and t+1 (forwarding), then data -2 at t+5. Drain shows bank 3 addr 2*4+1=9 = 8; all other entries 0.
- All 32 banks write every cycle for 10 cycles with data 1 at one addr each. Drain shows 10 in each bank at that addr; dropped_write stays 0.
- Drain with drain_ready toggled 1,0,0,1: drain_addr/drain_data stay frozen across stalls; no beat is duplicated or skipped; the FSM returns to IDLE after addr 511.
- Write during DRAIN: dropped_write goes 1 and the drained data is unchanged. reset_n low mid-drain: drain_valid 0 immediately, busy 0.
- SATURATE_EN: 0x7FF0 + 0x0020 reads back 0x7FFF. Without the macro it reads back 0x8010.
